// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback unit.
//   XLEN     : datapath width
//   REG_AW   : register address width
//   wb_req_t : one pending register write {rd, data}
//   is_x0()  : true when a destination is the hard-wired zero register
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  function automatic logic is_x0(input logic [REG_AW-1:0] rd);
    return (rd == '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding load responses waiting for the write port.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   push, push_data      : enqueue one entry (caller guarantees !full)
//   pop                  : dequeue the head (caller guarantees !empty)
//   full, empty          : occupancy flags
//   head                 : current head entry, valid while !empty
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  wb_req_t       mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: merges ALU results and load responses into the single
// register-file write port, and tracks registers with outstanding loads.
// Ports:
//   issue_valid/issue_is_load/issue_rd, rs1, rs2 : instruction being issued
//   hazard, busy                                 : stall request, scoreboard
//   alu_valid/alu_ready/alu_rd/alu_data          : ALU result handshake
//   ld_valid/ld_ready/ld_rd/ld_data              : load response handshake
//   rf_we/rf_ad/rf_wd                            : registered write port
// Build option: define WB_LOAD_BYPASS_EN to let a load arriving at an empty
// buffer go straight to the write port (1-cycle latency). Without it every
// load is buffered first (at least 2-cycle latency).
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN     = wb_pkg::XLEN,
  parameter int NREG     = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic            issue_is_load,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard,
  output logic [NREG-1:0] busy,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_we,
  output logic [4:0]      rf_ad,
  output logic [XLEN-1:0] rf_wd
);

  logic    fifo_full, fifo_empty, push, pop, bypass;
  wb_req_t fifo_head, ld_req, alu_req, sel_req;
  logic    sel_valid, sel_is_ld;

  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_ad_q, rf_ad_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;
  logic            wr_is_ld_q, wr_is_ld_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign ld_req  = '{rd: ld_rd, data: ld_data};
  assign alu_req = '{rd: alu_rd, data: alu_data};

`ifdef WB_LOAD_BYPASS_EN
  // An empty buffer means ld_ready is high, so ld_valid alone is a handshake.
  assign bypass = fifo_empty & ld_valid;
`else
  assign bypass = 1'b0;
`endif

  assign ld_ready  = !fifo_full;
  assign alu_ready = fifo_empty & !bypass;
  assign push      = ld_valid & ld_ready & !bypass;
  assign pop       = !fifo_empty;

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (ld_req),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Fixed priority: buffered load, then bypassed load, then ALU result.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    sel_valid = 1'b0;
    sel_is_ld = 1'b0;
    sel_req   = alu_req;
    if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_is_ld = 1'b1;
      sel_req   = fifo_head;
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_is_ld = 1'b1;
      sel_req   = ld_req;
    end else if (alu_valid) begin
      sel_valid = 1'b1;
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_comb begin
    rf_we_d    = sel_valid & !is_x0(sel_req.rd);
    rf_ad_d    = sel_valid ? sel_req.rd   : rf_ad_q;
    rf_wd_d    = sel_valid ? sel_req.data : rf_wd_q;
    wr_is_ld_d = sel_valid & sel_is_ld;
  end

  // Scoreboard: the clear is applied first so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q && wr_is_ld_q) busy_d[rf_ad_q] = 1'b0;
    if (issue_valid && issue_is_load && !is_x0(issue_rd)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_ad_q    <= '0;
      rf_wd_q    <= '0;
      wr_is_ld_q <= 1'b0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_ad_q    <= rf_ad_d;
      rf_wd_q    <= rf_wd_d;
      wr_is_ld_q <= wr_is_ld_d;
      busy_q     <= busy_d;
    end
  end

  assign hazard = busy_q[rs1] | busy_q[rs2] | (issue_valid & busy_q[issue_rd]);
  assign busy   = busy_q;
  assign rf_we  = rf_we_q;
  assign rf_ad  = rf_ad_q;
  assign rf_wd  = rf_wd_q;

endmodule
